keypad_scan_encoder: RTL and testbench



---
 rtl/keypad_pkg.sv | 28 ++
 rtl/keypad_row_scanner.sv | 75 +++++++
 rtl/keypad_scan_encoder.sv | 130 +++++++++++++
 tb/tb_keypad_scan_encoder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and key-code mapping for the 3x4 keypad scan encoder.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} kp_state_e;

  typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_res_e;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  typedef struct packed {
    scan_res_e  res;
    logic [3:0] code;
  } scan_rsp_t;

  // Phone layout: rows 0..2 hold 1..9, bottom row is '*', '0', '#'.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    if (row == 2'd3) begin
      case (col)
        2'd0:    return KEY_STAR;
        2'd1:    return 4'h0;
        default: return KEY_HASH;
      endcase
    end
    return ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
  endfunction

endpackage

// File: rtl/keypad_row_scanner.sv
// Drives keypad rows one-hot, samples columns at the end of each row dwell and
// reports a per-scan NONE/SINGLE/MULTI result with a one-cycle valid strobe.
module keypad_row_scanner
  import keypad_pkg::*;
#(
  parameter int ROW_DWELL = 100000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [2:0] COLS,
  output logic [3:0] ROWS,
  output logic       scan_vld,
  output scan_rsp_t  scan_rsp
);

  localparam int              DCW        = $clog2(ROW_DWELL);
  localparam logic [DCW-1:0]  DWELL_LAST = DCW'(ROW_DWELL - 1);

  logic [1:0]     row_idx;
  logic [DCW-1:0] dwell_cnt;
  logic [1:0]     acc_cnt;
  logic [3:0]     acc_code;

  logic       sample;
  logic [1:0] row_cnt;
  logic [3:0] row_code;
  logic [2:0] sum_cnt;
  logic [1:0] tot_cnt;
  logic [3:0] tot_code;

  assign sample = (dwell_cnt == DWELL_LAST);
  assign ROWS   = 4'b0001 << row_idx;

  // Key count saturates at 2; only "none / one / more" matters downstream.
  always_comb begin
    row_cnt  = '0;
    row_code = '0;
    for (int c = 0; c < 3; c++) begin
      if (COLS[c]) begin
        row_cnt  = row_cnt + 2'd1;
        row_code = key_code(row_idx, 2'(c));
      end
    end
    sum_cnt  = {1'b0, acc_cnt} + {1'b0, row_cnt};
    tot_cnt  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
    tot_code = (row_cnt != 2'd0) ? row_code : acc_code;
  end

  assign scan_vld      = sample && (row_idx == 2'd3);
  assign scan_rsp.code = tot_code;
  assign scan_rsp.res  = (tot_cnt == 2'd0) ? NONE :
                         (tot_cnt == 2'd1) ? SINGLE : MULTI;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      row_idx   <= '0;
      dwell_cnt <= '0;
      acc_cnt   <= '0;
      acc_code  <= '0;
    end else if (sample) begin
      dwell_cnt <= '0;
      row_idx   <= row_idx + 2'd1;
      if (row_idx == 2'd3) begin
        acc_cnt  <= '0;
        acc_code <= '0;
      end else begin
        acc_cnt  <= tot_cnt;
        acc_code <= tot_code;
      end
    end else begin
      dwell_cnt <= dwell_cnt + DCW'(1);
    end
  end

endmodule

// File: rtl/keypad_scan_encoder.sv
// Keypad front end: debounces per-scan results into accepted key codes and
// raises a fixed-width interrupt pulse for each accepted press.
module keypad_scan_encoder
  import keypad_pkg::*;
#(
  parameter int ROW_DWELL      = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int INT_WIDTH      = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [2:0] COLS,
  output logic [3:0] ROWS,
  output logic [3:0] DATA,
  output logic       KEY_VALID,
  output logic       INTERRUPT
);

  localparam int             DBW      = $clog2(DEBOUNCE_SCANS + 1);
  localparam int             IW       = $clog2(INT_WIDTH + 1);
  localparam logic [DBW-1:0] DEB_LAST = DBW'(DEBOUNCE_SCANS - 1);

  logic      scan_vld;
  scan_rsp_t scan_rsp;

  kp_state_e      state, state_nxt;
  logic [3:0]     cand, cand_nxt;
  logic [DBW-1:0] deb_cnt, cnt_nxt;
  logic           accept;
  logic [IW-1:0]  int_cnt;

  keypad_row_scanner #(.ROW_DWELL(ROW_DWELL)) u_scanner (
    .CLK      (CLK),
    .RESET    (RESET),
    .COLS     (COLS),
    .ROWS     (ROWS),
    .scan_vld (scan_vld),
    .scan_rsp (scan_rsp)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      cand    <= '0;
      deb_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cand    <= cand_nxt;
      deb_cnt <= cnt_nxt;
    end
  end

  // The FSM only moves on scan-result cycles; all other cycles hold.
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = deb_cnt;
    accept    = 1'b0;
    if (scan_vld) begin
      case (state)
        IDLE: begin
          if (scan_rsp.res == SINGLE) begin
            cand_nxt = scan_rsp.code;
            if (DEBOUNCE_SCANS == 1) begin
              accept    = 1'b1;
              state_nxt = HELD;
            end else begin
              cnt_nxt   = DBW'(1);
              state_nxt = DEB_PRESS;
            end
          end
        end
        DEB_PRESS: begin
          if (scan_rsp.res == SINGLE) begin
            if (scan_rsp.code == cand) begin
              if (deb_cnt == DEB_LAST) begin
                accept    = 1'b1;
                state_nxt = HELD;
              end else begin
                cnt_nxt = deb_cnt + DBW'(1);
              end
            end else begin
              cand_nxt = scan_rsp.code;
              cnt_nxt  = DBW'(1);
            end
          end else begin
            state_nxt = IDLE;
          end
        end
        HELD: begin
          if (scan_rsp.res == NONE) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_nxt = IDLE;
            end else begin
              cnt_nxt   = DBW'(1);
              state_nxt = DEB_RELEASE;
            end
          end
        end
        DEB_RELEASE: begin
          if (scan_rsp.res == NONE) begin
            if (deb_cnt == DEB_LAST) state_nxt = IDLE;
            else                     cnt_nxt   = deb_cnt + DBW'(1);
          end else begin
            state_nxt = HELD;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      DATA      <= '0;
      KEY_VALID <= 1'b0;
      int_cnt   <= '0;
    end else begin
      if (accept) begin
        DATA      <= cand_nxt;
        KEY_VALID <= 1'b1;
      end
      if (accept)              int_cnt <= IW'(INT_WIDTH);
      else if (int_cnt != '0)  int_cnt <= int_cnt - IW'(1);
    end
  end

  assign INTERRUPT = (int_cnt != '0);

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed bench for keypad_scan_encoder with ROW_DWELL=4, DEBOUNCE_SCANS=3,
// INT_WIDTH=4 (16-cycle scans); a key matrix model drives COLS from ROWS.
module tb_keypad_scan_encoder;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [2:0] COLS;
  logic [3:0] ROWS;
  logic [3:0] DATA;
  logic       KEY_VALID;
  logic       INTERRUPT;

  logic [3:0][2:0] keys = '0;
  int   checks = 0;
  int   errors = 0;
  int   int_hi = 0;
  int   int_rise = 0;
  logic int_prev = 1'b0;

  always #5 CLK = ~CLK;

  always_comb begin
    COLS = '0;
    for (int r = 0; r < 4; r++)
      if (ROWS[r]) COLS = COLS | keys[r];
  end

  keypad_scan_encoder #(.ROW_DWELL(4), .DEBOUNCE_SCANS(3), .INT_WIDTH(4)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .COLS      (COLS),
    .ROWS      (ROWS),
    .DATA      (DATA),
    .KEY_VALID (KEY_VALID),
    .INTERRUPT (INTERRUPT)
  );

  // Advance n cycles, sampling on the falling edge and tracking the pulse.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLK);
      if (INTERRUPT) int_hi++;
      if (INTERRUPT && !int_prev) int_rise++;
      int_prev = INTERRUPT;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    int_hi   = 0;
    int_rise = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rows"}, 8'(ROWS), 8'h1);
    check({tag, "_data"}, 8'(DATA), 8'h0);
    check({tag, "_kv"},   8'(KEY_VALID), 8'h0);
    check({tag, "_int"},  8'(INTERRUPT), 8'h0);
  endtask

  initial begin
    logic [3:0] exp_rows;

    // 1: reset state, row stepping, idle outputs
    RESET = 1'b1;
    step(2);
    check_reset_vals("rst0");
    RESET = 1'b0;
    check("rows_k0", 8'(ROWS), 8'h1);
    for (int k = 1; k < 32; k++) begin
      step(1);
      exp_rows = 4'b0001 << ((k / 4) % 4);
      check("rows_seq", 8'(ROWS), 8'(exp_rows));
    end
    for (int k = 32; k < 500; k++) begin
      step(1);
      check("idle", {2'b00, DATA, KEY_VALID, INTERRUPT}, 8'h0);
    end

    // 2: hold '5' from a scan boundary
    RESET = 1'b1;
    step(1);
    check_reset_vals("rst1");
    RESET = 1'b0;
    keys[1][1] = 1'b1;
    clr();
    step(47);
    check("k5_early_kv", 8'(KEY_VALID), 8'h0);
    step(1);
    check("k5_data", 8'(DATA), 8'h5);
    check("k5_kv",   8'(KEY_VALID), 8'h1);
    check("k5_int",  8'(INTERRUPT), 8'h1);
    step(19 * 16);
    check("k5_int_width", 8'(int_hi), 8'd4);
    check("k5_int_count", 8'(int_rise), 8'd1);

    // 3: release, then '#', then a short release must not re-trigger
    keys = '0;
    step(48);
    keys[3][2] = 1'b1;
    clr();
    step(47);
    check("hash_early_data", 8'(DATA), 8'h5);
    step(1);
    check("hash_data", 8'(DATA), 8'hB);
    check("hash_int",  8'(INTERRUPT), 8'h1);
    step(16);
    check("hash_int_width", 8'(int_hi), 8'd4);
    keys = '0;
    step(32);
    keys[3][2] = 1'b1;
    step(64);
    check("hash_short_rel", 8'(int_rise), 8'd1);
    check("hash_hold_data", 8'(DATA), 8'hB);

    // 4: bounce on '1'
    keys = '0;
    step(48);
    keys[0][0] = 1'b1;
    clr();
    step(16);
    keys = '0;
    step(16);
    keys[0][0] = 1'b1;
    step(32);
    check("bounce_no_int", 8'(int_rise), 8'd0);
    check("bounce_data",   8'(DATA), 8'hB);
    step(16);
    check("bounce_accept", 8'(DATA), 8'h1);
    check("bounce_int",    8'(INTERRUPT), 8'h1);
    step(16);
    check("bounce_pulse_w", 8'(int_hi), 8'd4);
    check("bounce_pulse_n", 8'(int_rise), 8'd1);

    // Re-accept '5' so the multi-key test can see DATA change to 1
    keys = '0;
    step(48);
    keys[1][1] = 1'b1;
    step(48);
    check("pre5_data", 8'(DATA), 8'h5);
    keys = '0;
    step(48);

    // 5: '1' and '3' together are never accepted
    keys[0][0] = 1'b1;
    keys[0][2] = 1'b1;
    clr();
    step(160);
    check("multi_no_int", 8'(int_rise), 8'd0);
    check("multi_data",   8'(DATA), 8'h5);
    keys[0][2] = 1'b0;
    step(47);
    check("multi_rel_early", 8'(DATA), 8'h5);
    step(1);
    check("multi_rel_data", 8'(DATA), 8'h1);
    check("multi_rel_int",  8'(INTERRUPT), 8'h1);

    // 6: reset mid-debounce and mid-pulse
    keys = '0;
    step(48);
    keys[2][0] = 1'b1;
    step(40);
    RESET = 1'b1;
    step(1);
    check_reset_vals("rst_deb");
    RESET = 1'b0;
    step(47);
    check("rst_deb_kv", 8'(KEY_VALID), 8'h0);
    step(1);
    check("k7_data", 8'(DATA), 8'h7);
    check("k7_int",  8'(INTERRUPT), 8'h1);
    step(2);
    check("k7_int_mid", 8'(INTERRUPT), 8'h1);
    RESET = 1'b1;
    step(1);
    check_reset_vals("rst_pulse");
    RESET = 1'b0;
    step(47);
    check("rst_pulse_kv", 8'(KEY_VALID), 8'h0);
    step(1);
    check("k7_reaccept", 8'(DATA), 8'h7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
